// File: rtl/bf_io_uart_pkg.sv
// Shared constants for the brainfuck CPU UART I/O slave:
// direction encoding, 8N1 frame shape and FSM state encodings.
package bf_io_uart_pkg;

    localparam logic DIRECTION_READ  = 1'b0;
    localparam logic DIRECTION_WRITE = 1'b1;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_WAIT = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_ACK     = 2'd3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    typedef logic [7:0] byte_t;

    function automatic logic last_data_bit(input logic [2:0] idx);
        return idx == 3'(DATA_BITS - 1);
    endfunction

endpackage

// File: rtl/bf_io_uart_if.sv
// CPU-side byte I/O handshake: request/direction/data out,
// acknowledge/read data back.
interface bf_io_uart_if;
    logic       io_req;
    logic       io_dir;
    logic [7:0] io_wdata;
    logic       io_ack;
    logic [7:0] io_rdata;

    modport master (
        output io_req, io_dir, io_wdata,
        input  io_ack, io_rdata
    );

    modport slave (
        input  io_req, io_dir, io_wdata,
        output io_ack, io_rdata
    );
endinterface

// File: rtl/bf_io_fifo.sv
// Synchronous show-ahead byte FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module bf_io_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [7:0]            mem [2**DEPTH_LOG2];
    logic                  do_push;
    logic                  do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/bf_io_uart.sv
// 8N1 UART bridge for the brainfuck CPU io port. BF_IO_RX_FIFO_EN
// selects a 2^RX_DEPTH_LOG2 RX FIFO instead of a one-byte holding register.
module bf_io_uart
    import bf_io_uart_pkg::*;
#(
    parameter int CLK_DIV       = 868,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    bf_io_uart_if.slave   io,
    output logic          uart_txd,
    input  logic          uart_rxd,
    output logic          rx_overrun,
    output logic          rx_frame_err
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);

    logic [1:0]    slv_state;
    logic [1:0]    tx_state;
    logic [DW-1:0] tx_div;
    logic [2:0]    tx_bit;
    byte_t         tx_sh;
    logic          tx_ready;
    logic          tx_load;

    logic          rx_s1;
    logic          rx_s;
    logic [1:0]    rx_state;
    logic [DW-1:0] rx_div;
    logic [2:0]    rx_bit;
    byte_t         rx_sh;
    logic          rx_ferr;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_full;
    logic          rx_empty;
    byte_t         rx_rdata;

    // Loading on the last STOP cycle lets frames run back to back.
    assign tx_ready = (tx_state == TX_IDLE) ||
                      (tx_state == TX_STOP && tx_div == '0);
    assign tx_load  = (slv_state == S_WR_WAIT) && tx_ready;
    assign rx_pop   = (slv_state == S_RD_WAIT) && !rx_empty;
    assign rx_push  = (rx_state == RX_STOP) && (rx_div == '0) &&
                      rx_s && !rx_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slv_state   <= S_IDLE;
            io.io_ack   <= 1'b0;
            io.io_rdata <= '0;
        end else begin
            unique case (1'b1)
                slv_state == S_IDLE: begin
                    if (io.io_req && !io.io_ack)
                        slv_state <= (io.io_dir == DIRECTION_READ) ?
                                     S_RD_WAIT : S_WR_WAIT;
                end
                slv_state == S_WR_WAIT: begin
                    if (tx_ready) begin
                        slv_state <= S_ACK;
                        io.io_ack <= 1'b1;
                    end
                end
                slv_state == S_RD_WAIT: begin
                    if (!rx_empty) begin
                        io.io_rdata <= rx_rdata;
                        slv_state   <= S_ACK;
                        io.io_ack   <= 1'b1;
                    end
                end
                slv_state == S_ACK: begin
                    if (!io.io_req) begin
                        io.io_ack <= 1'b0;
                        slv_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_txd <= 1'b1;
        end else if (tx_load) begin
            tx_state <= TX_START;
            tx_div   <= DIV_LAST;
            tx_bit   <= '0;
            tx_sh    <= io.io_wdata;
            uart_txd <= 1'b0;
        end else if (tx_state != TX_IDLE) begin
            if (tx_div != '0) begin
                tx_div <= tx_div - 1'b1;
            end else begin
                tx_div <= DIV_LAST;
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        uart_txd <= tx_sh[0];
                    end
                    TX_DATA: begin
                        if (last_data_bit(tx_bit)) begin
                            tx_state <= TX_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_sh    <= tx_sh >> 1;
                            uart_txd <= tx_sh[1];
                        end
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1        <= 1'b1;
            rx_s         <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_div       <= '0;
            rx_bit       <= '0;
            rx_sh        <= '0;
            rx_ferr      <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1 <= uart_rxd;
            rx_s  <= rx_s1;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= RX_START;
                        rx_div   <= DIV_HALF;
                    end
                end
                RX_START: begin
                    if (rx_div != '0) begin
                        rx_div <= rx_div - 1'b1;
                    end else if (rx_s) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_state <= RX_DATA;
                        rx_div   <= DIV_LAST;
                        rx_bit   <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_div != '0) begin
                        rx_div <= rx_div - 1'b1;
                    end else begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_div <= DIV_LAST;
                        if (last_data_bit(rx_bit)) rx_state <= RX_STOP;
                        else                       rx_bit   <= rx_bit + 1'b1;
                    end
                end
                default: begin
                    // After a bad stop bit, hold here until the line idles.
                    if (rx_ferr) begin
                        if (rx_s) begin
                            rx_ferr  <= 1'b0;
                            rx_state <= RX_IDLE;
                        end
                    end else if (rx_div != '0) begin
                        rx_div <= rx_div - 1'b1;
                    end else if (rx_s) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_ferr      <= 1'b1;
                        rx_frame_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             rx_overrun <= 1'b0;
        else if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
    end

`ifdef BF_IO_RX_FIFO_EN
    bf_io_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_sh),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty)
    );
`else
    logic rx_valid;

    assign rx_full  = rx_valid;
    assign rx_empty = !rx_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_rdata <= '0;
        end else if (rx_push && (!rx_valid || rx_pop)) begin
            rx_valid <= 1'b1;
            rx_rdata <= rx_sh;
        end else if (rx_pop) begin
            rx_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bf_io_uart.sv
// Directed bench for bf_io_uart with TX/RX byte scoreboards.
// Works in both the FIFO and holding-register builds.
module tb_bf_io_uart;
    import bf_io_uart_pkg::*;

    localparam int CLK_DIV = 16;
`ifdef BF_IO_RX_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic uart_txd;
    logic uart_rxd;
    logic rx_overrun;
    logic rx_frame_err;

    bf_io_uart_if io ();

    bf_io_uart #(.CLK_DIV(CLK_DIV), .RX_DEPTH_LOG2(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .io           (io.slave),
        .uart_txd     (uart_txd),
        .uart_rxd     (uart_rxd),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    byte unsigned tx_q[$];
    byte unsigned rd_q[$];
    int tx_starts[$];
    bit mon_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // TX monitor: checks first and last cycle of every bit.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst === 1'b0 && uart_txd === 1'b0) begin : frame
                byte unsigned b;
                logic [9:0] pat;
                tx_starts.push_back(cyc);
                checks++;
                assert (tx_q.size() != 0) else begin
                    failures++;
                    $error("FAIL tx_unexpected_frame observed=%0d expected=1",
                           tx_q.size());
                end
                b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
                pat = {1'b1, b, 1'b0};
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < CLK_DIV; j++) begin
                        if (k != 0 || j != 0) begin
                            @(posedge clk);
                            #1;
                        end
                        if (j == 0 || j == CLK_DIV - 1)
                            chk($sformatf("tx_%02h_bit%0d_c%0d", b, k, j),
                                {31'd0, uart_txd}, {31'd0, pat[k]});
                    end
                end
            end
        end
    end

    task automatic do_write(input byte unsigned b, output int lat,
                            output int ack_cyc);
        int c0;
        int n;
        io.io_dir   = DIRECTION_WRITE;
        io.io_wdata = b;
        io.io_req   = 1'b1;
        tx_q.push_back(b);
        c0 = cyc;
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (io.io_ack !== 1'b1 && n < 3000);
        chk("wr_ack_rise", {31'd0, io.io_ack}, 32'd1);
        lat = cyc - c0;
        ack_cyc = cyc;
        io.io_req = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (io.io_ack !== 1'b0 && n < 10);
        chk("wr_ack_fall_lat", n, 1);
    endtask

    task automatic do_read(output int lat, output int ack_cyc);
        int c0;
        int n;
        byte unsigned e;
        io.io_dir = DIRECTION_READ;
        io.io_req = 1'b1;
        c0 = cyc;
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (io.io_ack !== 1'b1 && n < 5000);
        chk("rd_ack_rise", {31'd0, io.io_ack}, 32'd1);
        lat = cyc - c0;
        ack_cyc = cyc;
        checks++;
        assert (rd_q.size() != 0) else begin
            failures++;
            $error("FAIL rd_unexpected observed=%0d expected=1", rd_q.size());
        end
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
        chk("rd_data", {24'd0, io.io_rdata}, {24'd0, e});
        io.io_req = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (io.io_ack !== 1'b0 && n < 10);
        chk("rd_ack_fall_lat", n, 1);
    endtask

    task automatic send_byte(input byte unsigned b, input logic stop_bit,
                             input bit expect_rx);
        logic [9:0] pat;
        if (expect_rx) rd_q.push_back(b);
        pat = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rxd = pat[k];
            repeat (CLK_DIV) @(posedge clk);
            #1;
        end
        uart_rxd = 1'b1;
    endtask

    initial begin : main
        int lat;
        int a1;
        int a2;
        int cs;
        rst         = 1'b1;
        io.io_req   = 1'b0;
        io.io_dir   = DIRECTION_READ;
        io.io_wdata = 8'h00;
        uart_rxd    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, io.io_ack}, 32'd0);
        chk("rst_rdata", {24'd0, io.io_rdata}, 32'd0);
        chk("rst_txd", {31'd0, uart_txd}, 32'd1);
        chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
        chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        do_write(8'h41, lat, a1);
        chk("wr_lat", lat, 2);
        repeat (170) @(posedge clk);
        #1;
        chk("tx_frames_41", tx_starts.size(), 1);
        if (tx_starts.size() != 0) chk("tx_start_41", tx_starts.pop_front(), a1);

        do_write(8'h55, lat, a1);
        chk("wr_lat_55", lat, 2);
        do_write(8'hAA, lat, a2);
        chk("wr_b2b_ack", a2, a1 + 10 * CLK_DIV);
        repeat (170) @(posedge clk);
        #1;
        chk("tx_frames_b2b", tx_starts.size(), 2);
        if (tx_starts.size() == 2) begin
            chk("tx_start_55", tx_starts[0], a1);
            chk("tx_gap_aa", tx_starts[1], a1 + 10 * CLK_DIV);
        end
        tx_starts.delete();
        chk("tx_q_drained", tx_q.size(), 0);

        uart_rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_ferr", {31'd0, rx_frame_err}, 32'd0);

        cs = 0;
        fork
            do_read(lat, a2);
            begin
                repeat (100) @(posedge clk);
                #1;
                cs = cyc;
                send_byte(8'h3C, 1'b1, 1'b1);
            end
        join
        chk("rx_latency", a2 - cs, 10 * CLK_DIV - CLK_DIV / 2 - 3 + 7);

        chk("pre_ovr", {31'd0, rx_overrun}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            send_byte(byte'(i), 1'b1, i < DEPTH);
            if (i == DEPTH - 1)
                chk("full_no_ovr", {31'd0, rx_overrun}, 32'd0);
        end
        repeat (5) @(posedge clk);
        #1;
        chk("ovr_set", {31'd0, rx_overrun}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            do_read(lat, a2);
            chk($sformatf("rd_buf_lat%0d", i), lat, 2);
        end
        chk("rd_q_drained", rd_q.size(), 0);

        chk("pre_ferr", {31'd0, rx_frame_err}, 32'd0);
        send_byte(8'h7E, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("ferr_set", {31'd0, rx_frame_err}, 32'd1);
        chk("ovr_sticky", {31'd0, rx_overrun}, 32'd1);
        fork
            do_read(lat, a2);
            begin
                repeat (20) @(posedge clk);
                #1;
                send_byte(8'h12, 1'b1, 1'b1);
            end
        join
        chk("rd_q_final", rd_q.size(), 0);

        mon_en      = 1'b0;
        io.io_dir   = DIRECTION_WRITE;
        io.io_wdata = 8'h00;
        io.io_req   = 1'b1;
        for (int n = 0; n < 3000 && io.io_ack !== 1'b1; n++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_wr_ack", {31'd0, io.io_ack}, 32'd1);
        repeat (40) @(posedge clk);
        #3;
        chk("txd_mid_frame", {31'd0, uart_txd}, 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_txd", {31'd0, uart_txd}, 32'd1);
        chk("arst_ack", {31'd0, io.io_ack}, 32'd0);
        chk("arst_rdata", {24'd0, io.io_rdata}, 32'd0);
        chk("arst_ovr", {31'd0, rx_overrun}, 32'd0);
        chk("arst_ferr", {31'd0, rx_frame_err}, 32'd0);
        io.io_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_txd", {31'd0, uart_txd}, 32'd1);
        chk("post_rst_ack", {31'd0, io.io_ack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
